// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and bit-timing helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int clks_per_bit(input int clock_freq, input int bit_rate);
    return clock_freq / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side view of the UART receive buffer: FWFT read port plus error pulses.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int BUFFER_SIZE = 16
);

  logic                               rd_en;
  logic [DATA_BITS-1:0]               rd_data;
  logic                               empty;
  logic                               full;
  logic [$clog2(BUFFER_SIZE+1)-1:0]   count;
  logic                               frame_error;
  logic                               overrun;

  modport master (
    output rd_en,
    input  rd_data, empty, full, count, frame_error, overrun
  );

  modport slave (
    input  rd_en,
    output rd_data, empty, full, count, frame_error, overrun
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB tells a wrapped (full) FIFO from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; rd_data is masked while empty so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM, FWFT receive buffer.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ  = 27000000,
  parameter int BIT_RATE    = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  uart_rx_fifo_if.slave bus
);

  localparam int CPB   = clks_per_bit(CLOCK_FREQ, BIT_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  // Starting here puts the first terminal count half a bit after the falling edge.
  localparam logic [CNT_W-1:0] CNT_PRELOAD = CNT_W'(CPB - 1 - CPB / 2);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  logic                 rx_meta;
  logic                 rxs;
  rx_state_e            state;
  rx_state_e            next_state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 push;
  logic                 stop_bad;
  logic                 fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {rx_meta, rxs} <= 2'b11;
    else        {rx_meta, rxs} <= {rx, rx_meta};
  end

  assign tick = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: default assignment first so no path through the case leaves next_state unassigned.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rxs) next_state = START;
      START:   if (tick) next_state = rxs ? IDLE : DATA;
      DATA:    if (tick && bit_idx == IDX_LAST) next_state = STOP;
      STOP:    if (tick) next_state = rxs ? IDLE : BREAK;
      BREAK:   if (rxs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    stop_bad = 1'b0;
    if (state == STOP && tick) begin
      push     = rxs;
      stop_bad = !rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE:    baud_cnt <= rxs ? '0 : CNT_PRELOAD;
        BREAK:   baud_cnt <= '0;
        default: baud_cnt <= tick ? '0 : baud_cnt + CNT_ONE;
      endcase
      if (state == START) bit_idx <= '0;
      if (state == DATA && tick) begin
        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + IDX_ONE;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push),
    .wr_data (shreg),
    .pop     (bus.rd_en),
    .rd_data (bus.rd_data),
    .empty   (bus.empty),
    .full    (fifo_full),
    .count   (bus.count)
  );

  assign bus.full = fifo_full;

  // A full FIFO is never empty, so rd_en alone means a same-cycle pop frees a slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.frame_error <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.frame_error <= stop_bad;
      bus.overrun     <= push && fifo_full && !bus.rd_en;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, timed corner sequences, random frames vs a queue model.
module tb_uart_rx_fifo;

  localparam int CLOCK_FREQ  = 3000000;
  localparam int BIT_RATE    = 115200;
  localparam int BUFFER_SIZE = 16;
  localparam int CPB         = CLOCK_FREQ / BIT_RATE;
  // Edges from the start-bit drive to the stop-bit sample: 2 sync, 1 idle detect, half bit + 1, 9 bits.
  localparam int PUSH_EDGE   = 4 + CPB / 2 + 9 * CPB;
  localparam int GLITCH      = CPB * 100 / 234;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.BUFFER_SIZE(BUFFER_SIZE)) bus ();

  uart_rx_fifo #(
    .CLOCK_FREQ  (CLOCK_FREQ),
    .BIT_RATE    (BIT_RATE),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ov = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
  int n_vec = 0, n_err = 0;

  always @(negedge clk) begin
    if (bus.frame_error) fe_cnt++;
    if (bus.overrun) ov_cnt++;
    if (bus.frame_error && bus.overrun) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue updated from the frame-level rules.
  function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit pop_same);
    bit popped;
    popped = 1'b0;
    if (!stop_ok) begin
      exp_fe++;
      return;
    end
    if (pop_same && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      popped = 1'b1;
    end
    if (exp_q.size() < BUFFER_SIZE || popped) exp_q.push_back(b);
    else exp_ov++;
  endfunction

  function automatic void model_pop();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endfunction

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check({tag, " count"},   32'(bus.count),   exp_q.size());
    check({tag, " empty"},   32'(bus.empty),   32'(exp_q.size() == 0));
    check({tag, " full"},    32'(bus.full),    32'(exp_q.size() == BUFFER_SIZE));
    check({tag, " rd_data"}, 32'(bus.rd_data), 32'(head));
    check({tag, " frame_error pulses"}, fe_cnt, exp_fe);
    check({tag, " overrun pulses"},     ov_cnt, exp_ov);
  endtask

  // All serial tasks start and end on a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic hold_line(input int bits, input logic level);
    rx = level;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    model_pop();
  endtask

  // Raises rd_en for exactly the cycle whose closing edge samples the stop bit.
  task automatic frame_with_pop(input logic [7:0] b);
    fork
      send_frame(b, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
      end
    join
    model_frame(b, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx = 1'b1;
    bus.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  typedef enum {V_FRAME, V_POP, V_GLITCH} vkind_e;
  typedef struct {
    vkind_e     kind;
    logic [7:0] data;
    bit         stop_ok;
    int         low_bits;
    int         exp_count;
    logic [7:0] exp_head;
    bit         exp_empty;
    int         exp_fe;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] b;
    bit bad;
    int pops;

    vecs[0]  = '{V_FRAME,  8'hA5, 1'b1, 0, 1, 8'hA5, 1'b0, 0};
    vecs[1]  = '{V_POP,    8'h00, 1'b1, 0, 0, 8'h00, 1'b1, 0};
    vecs[2]  = '{V_FRAME,  8'h00, 1'b1, 0, 1, 8'h00, 1'b0, 0};
    vecs[3]  = '{V_FRAME,  8'hFF, 1'b1, 0, 2, 8'h00, 1'b0, 0};
    vecs[4]  = '{V_FRAME,  8'h55, 1'b1, 0, 3, 8'h00, 1'b0, 0};
    vecs[5]  = '{V_POP,    8'h00, 1'b1, 0, 2, 8'hFF, 1'b0, 0};
    vecs[6]  = '{V_POP,    8'h00, 1'b1, 0, 1, 8'h55, 1'b0, 0};
    vecs[7]  = '{V_POP,    8'h00, 1'b1, 0, 0, 8'h00, 1'b1, 0};
    vecs[8]  = '{V_GLITCH, 8'h00, 1'b1, 0, 0, 8'h00, 1'b1, 0};
    vecs[9]  = '{V_FRAME,  8'h3C, 1'b0, 5, 0, 8'h00, 1'b1, 1};
    vecs[10] = '{V_FRAME,  8'h81, 1'b1, 0, 1, 8'h81, 1'b0, 1};

    bus.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check_state("in reset");
    reset = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      case (vecs[i].kind)
        V_FRAME: begin
          send_frame(vecs[i].data, vecs[i].stop_ok);
          model_frame(vecs[i].data, vecs[i].stop_ok, 1'b0);
          if (vecs[i].low_bits > 0 || !vecs[i].stop_ok) begin
            hold_line(vecs[i].low_bits, 1'b0);
            hold_line(1, 1'b1);
          end
        end
        V_POP: pop_one();
        default: begin
          rx = 1'b0;
          repeat (GLITCH) @(negedge clk);
          rx = 1'b1;
          repeat (12 * CPB) @(negedge clk);
        end
      endcase
      check($sformatf("vec%0d count", i),   32'(bus.count),   vecs[i].exp_count);
      check($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_head));
      check($sformatf("vec%0d empty", i),   32'(bus.empty),   32'(vecs[i].exp_empty));
      check($sformatf("vec%0d frame_error pulses", i), fe_cnt, vecs[i].exp_fe);
      check($sformatf("vec%0d overrun pulses", i),     ov_cnt, 0);
    end

    // Exact latency, then push and pop together on an empty FIFO
    do_reset();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) @(negedge clk);
        check("latency empty before push", 32'(bus.empty), 1);
        @(negedge clk);
        check("latency empty after push", 32'(bus.empty), 0);
        check("latency rd_data", 32'(bus.rd_data), 32'h A5);
      end
    join
    model_frame(8'hA5, 1'b1, 1'b0);
    check_state("latency frame");
    pop_one();
    check_state("latency pop");
    frame_with_pop(8'h6B);
    check_state("push+pop on empty");

    // Fill past capacity, then push and pop together while full
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1'b1);
      model_frame(8'(i), 1'b1, 1'b0);
      check_state($sformatf("fill byte %0d", i));
    end
    frame_with_pop(8'hC3);
    check_state("push+pop on full");
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      pop_one();
      check_state($sformatf("drain %0d", i));
    end
    pop_one();
    check_state("pop on empty");

    // Asynchronous reset in the middle of a data bit
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_frame(b, 1'b1, 1'b0);
    end
    check_state("three buffered");
    hold_line(1, 1'b0);
    hold_line(2, 1'b1);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("async reset count", 32'(bus.count), 0);
    check("async reset empty", 32'(bus.empty), 1);
    check("async reset rd_data", 32'(bus.rd_data), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (CPB) @(negedge clk);
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1, 1'b0);
    check_state("frame after reset");

    // Random traffic against the queue model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      if (bad) begin
        send_frame(b, 1'b0);
        model_frame(b, 1'b0, 1'b0);
        hold_line($urandom_range(0, 3), 1'b0);
        hold_line(1, 1'b1);
      end else if ($urandom_range(0, 5) == 0) begin
        frame_with_pop(b);
      end else begin
        send_frame(b, 1'b1);
        model_frame(b, 1'b1, 1'b0);
      end
      check_state($sformatf("rand frame %0d", n));
      pops = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      for (int p = 0; p < pops; p++) begin
        pop_one();
        check_state($sformatf("rand %0d pop %0d", n, p));
      end
    end

    check("frame_error with overrun", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver with a receive buffer. It is the receive-side counterpart to the SoC UART transmitter.
- Deserialises 8N1 frames on `rx` into bytes and queues them in a first-word-fall-through (FWFT) FIFO. Consumers include the SoC bus peripheral and a host-side loader.
- Sits directly behind the board `rx` pin.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLOCK_FREQ, 27000000, system clock frequency in Hz.
- BIT_RATE, 115200, baud rate. CLKS_PER_BIT = CLOCK_FREQ/BIT_RATE, integer division (234 at defaults).
- BUFFER_SIZE, 16, FIFO depth in bytes. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  serial input; idle level is high; asynchronous to clk.
- rd_en  in  1  pop the head byte in this cycle.
- rd_data  out  8  head byte (FWFT); 0 when empty.
- empty  out  1  FIFO holds no bytes.
- full  out  1  count == BUFFER_SIZE.
- count  out  $clog2(BUFFER_SIZE+1)  number of bytes held.
- frame_error  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: received byte dropped because the FIFO is full.

Behaviour:
- Reset values:
  - Synchroniser flops = 1.
  - FSM in IDLE; bit counter and baud counter = 0.
  - FIFO pointers = 0, so count = 0, empty = 1, full = 0, rd_data = 0.
  - frame_error = 0, overrun = 0.
- Reset asserted mid-frame aborts the frame and flushes the FIFO.
- rx passes through a 2-FF synchroniser. All FSM decisions use the synchronised value `rxs`.
- Baud counter counts 0..CLKS_PER_BIT-1. The sample point occurs when the counter reaches its terminal value.
- FSM:
  - IDLE: on `rxs` == 0, go to START with the counter preloaded so that the first terminal count lands at CLKS_PER_BIT/2 (mid start bit).
  - START: at mid start bit, if `rxs` == 1 (glitch), return to IDLE with no output. Otherwise go to DATA with bit index = 0.
  - DATA: sample every CLKS_PER_BIT, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: sample at mid stop bit.
    - `rxs` == 1: byte is complete; push it to the FIFO and go to IDLE.
    - `rxs` == 0: pulse frame_error, discard the byte, go to BREAK.
  - BREAK: wait for `rxs` == 1, then go to IDLE. This prevents a held-low line from producing spurious frames.
- Latency: the byte is visible (empty falls, rd_data valid) on the cycle after the stop-bit sample edge. That is 2 sync cycles plus about 9.5 bit times after the rx falling edge.
- FIFO:
  - Storage is BUFFER_SIZE x 8. Pointers are $clog2(BUFFER_SIZE)+1 bits wide; the extra MSB distinguishes full from empty.
  - Pointer wrap at BUFFER_SIZE is natural.
  - Pop with rd_en while empty is ignored; no pointer change.
  - Push while full without a same-cycle pop: byte dropped, overrun pulses for 1 cycle, FIFO unchanged.
  - Push and pop in the same cycle while full: both succeed, count is unchanged, overrun = 0.
  - Push and pop in the same cycle while empty: push succeeds, pop is ignored, count becomes 1.
  - Otherwise, count = count + push - pop.
- frame_error and overrun are never asserted together. Both are registered.

Decomposition:
- Shared package (uart_pkg) holds:
  - rx FSM state enum: IDLE, START, DATA, STOP, BREAK;
  - the function clks_per_bit(CLOCK_FREQ, BIT_RATE);
  - DATA_BITS = 8.
- Sub-module: `sync_fifo` (parameters WIDTH and DEPTH; FWFT; push/pop/full/empty/count). It is reusable by the TX buffer.
- Synchroniser and deserialiser FSM stay in uart_rx_fifo.

Test Plan:
- Defaults (234 clk/bit). Send 0xA5 as 8N1 -> empty falls after about 2225 clk, rd_data = 0xA5, count = 1. Pulse rd_en -> empty = 1, rd_data = 0.
- Send 0x00, 0xFF, 0x55 back to back with no idle gap -> FIFO holds 3 bytes in order, no error pulses.
- 100-cycle low glitch on idle rx -> FSM returns to IDLE, count stays 0, no frame_error.
- Frame 0x3C with stop bit forced to 0, line held low for 5 bit times, then 0x81 sent normally -> exactly one frame_error pulse, FIFO contains only 0x81.
- 17 bytes 0x01..0x11 with no reads -> full = 1 after byte 16, overrun pulses once on byte 17, head = 0x01. On a later byte arriving while full with rd_en asserted in the same cycle as the push -> pop and push both succeed, count stays 16, no overrun.
- Assert reset low mid-DATA with 3 bytes buffered -> count = 0 and empty = 1 immediately (asynchronous). After release, the next clean frame 0x7E is received correctly.
